// File: rtl/cpu_types_pkg.sv
// Shared CPU types: request-sequencer state and the data-request pair.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package cpu_types_pkg;

    // Memory request sequencer state, shared with the hazard/pipeline logic
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } req_state_t;

    // Latched data-access type
    typedef struct packed {
        logic rd;
        logic wr;
    } dreq_t;

    // A store wins when both strobes are set, so rd and wr are never both 1
    function automatic dreq_t decode_dreq(input logic dren, input logic dwen);
        dreq_t r;
        r.wr = dwen;
        r.rd = dren & ~dwen;
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Unsigned up-counter that sticks at all-ones instead of wrapping.
// Latency: q reflects en one cycle later.
// Backpressure: none; en is sampled every cycle.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         en,
    output logic [W-1:0] q
);

    // Count up on en until the maximum value, then hold
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            q <= '0;
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/mem_request_unit.sv
// Sequences instruction fetch then optional data access; drives PC enable, halt and perf counters.
// Latency: ALU op retires in the ihit cycle; load/store retires in the dhit cycle (>= 2 cycles).
// Backpressure: waits indefinitely on ihit/dhit, counting each wait cycle as a stall.
module mem_request_unit
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             cu_dren,
    input  logic             cu_dwen,
    input  logic             cu_halt,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pc_en,
    output logic             halt,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] stall_count
);

    req_state_t state, state_nxt;
    dreq_t      dreq_q, dreq_nxt;
    logic       halt_q, halt_nxt;
    logic       pc_en_c;
    logic       retire;
    logic       stall;

    // State, latched data request and sticky halt
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= FETCH;
            dreq_q <= '0;
            halt_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            dreq_q <= dreq_nxt;
            halt_q <= halt_nxt;
        end
    end

    // Next-state, retire/stall strobes and the same-cycle PC advance
    always_comb begin
        state_nxt = state;
        dreq_nxt  = dreq_q;
        halt_nxt  = halt_q;
        pc_en_c   = 1'b0;
        retire    = 1'b0;
        stall     = 1'b0;
        case (state)
            FETCH: begin
                if (ihit) begin
                    if (cu_halt) begin
                        // HALT retires but never advances the PC; any memory strobe is dropped
                        state_nxt = HALTED;
                        halt_nxt  = 1'b1;
                        retire    = 1'b1;
                    end else if (cu_dren || cu_dwen) begin
                        state_nxt = DATA;
                        dreq_nxt  = decode_dreq(cu_dren, cu_dwen);
                    end else begin
                        pc_en_c = 1'b1;
                        retire  = 1'b1;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            DATA: begin
                // Request type is already latched; ihit and cu_* are don't-care here
                if (dhit) begin
                    state_nxt = FETCH;
                    dreq_nxt  = '0;
                    pc_en_c   = 1'b1;
                    retire    = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            HALTED: begin
                // Absorbing: counters frozen, nothing requested
            end
            default: begin
                state_nxt = FETCH;
                dreq_nxt  = '0;
            end
        endcase
    end

    // Gating by nRST keeps every request/enable low while reset is held
    assign imemREN = nRST && (state == FETCH);
    assign dmemREN = dreq_q.rd;
    assign dmemWEN = dreq_q.wr;
    assign pc_en   = nRST && pc_en_c;
    assign halt    = halt_q;

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .core_clk (CLK),
        .arst_n   (nRST),
        .en       (retire),
        .q        (instr_count)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .core_clk (CLK),
        .arst_n   (nRST),
        .en       (stall),
        .q        (stall_count)
    );

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed bench for mem_request_unit (32-bit counters) plus a 4-bit counter instance for saturation.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_mem_request_unit;

    logic        CLK;
    logic        nRST;
    logic        ihit, dhit, cu_dren, cu_dwen, cu_halt;
    logic        imemREN, dmemREN, dmemWEN, pc_en, halt;
    logic [31:0] instr_count, stall_count;

    logic        ihit4;
    logic        imemREN4, dmemREN4, dmemWEN4, pc_en4, halt4;
    logic [3:0]  instr_count4, stall_count4;

    int n_chk = 0;
    int n_err = 0;

    mem_request_unit #(.CNT_W(32)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .dhit        (dhit),
        .cu_dren     (cu_dren),
        .cu_dwen     (cu_dwen),
        .cu_halt     (cu_halt),
        .imemREN     (imemREN),
        .dmemREN     (dmemREN),
        .dmemWEN     (dmemWEN),
        .pc_en       (pc_en),
        .halt        (halt),
        .instr_count (instr_count),
        .stall_count (stall_count)
    );

    mem_request_unit #(.CNT_W(4)) dut4 (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit4),
        .dhit        (1'b0),
        .cu_dren     (1'b0),
        .cu_dwen     (1'b0),
        .cu_halt     (1'b0),
        .imemREN     (imemREN4),
        .dmemREN     (dmemREN4),
        .dmemWEN     (dmemWEN4),
        .pc_en       (pc_en4),
        .halt        (halt4),
        .instr_count (instr_count4),
        .stall_count (stall_count4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and land 1 time unit after it
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 0; dhit = 0; cu_dren = 0; cu_dwen = 0; cu_halt = 0; ihit4 = 0;
    endtask

    initial begin
        idle_inputs();
        nRST = 1'b0;
        #3;
        chk("rst_imemREN", imemREN, 0);
        chk("rst_dmemREN", dmemREN, 0);
        chk("rst_dmemWEN", dmemWEN, 0);
        chk("rst_halt", halt, 0);
        chk("rst_instr", instr_count, 0);
        chk("rst_stall", stall_count, 0);
        cyc(); cyc();
        nRST = 1'b1;

        // Three back-to-back ALU instructions
        ihit = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("alu_pc_en", pc_en, 1);
            chk("alu_imemREN", imemREN, 1);
            cyc();
        end
        ihit = 0;
        chk("alu_instr", instr_count, 3);
        chk("alu_stall", stall_count, 0);

        // Load: ihit at t0, dhit at t0+3
        ihit = 1; cu_dren = 1;
        #1;
        chk("ld_t0_pc_en", pc_en, 0);
        chk("ld_t0_dmemREN", dmemREN, 0);
        cyc();
        ihit = 0; cu_dren = 0; cu_dwen = 1;
        #1;
        chk("ld_t1_dmemREN", dmemREN, 1);
        chk("ld_t1_imemREN", imemREN, 0);
        chk("ld_t1_pc_en", pc_en, 0);
        cyc();
        cu_dwen = 0;
        chk("ld_t2_dmemREN", dmemREN, 1);
        chk("ld_t2_dmemWEN", dmemWEN, 0);
        chk("ld_t2_pc_en", pc_en, 0);
        cyc();
        dhit = 1;
        #1;
        chk("ld_t3_dmemREN", dmemREN, 1);
        chk("ld_t3_pc_en", pc_en, 1);
        cyc();
        dhit = 0;
        chk("ld_t4_imemREN", imemREN, 1);
        chk("ld_t4_dmemREN", dmemREN, 0);
        chk("ld_instr", instr_count, 4);
        chk("ld_stall", stall_count, 2);

        // Store with dhit at t0+1, ihit held high in DATA
        ihit = 1; cu_dwen = 1;
        #1;
        chk("st_t0_pc_en", pc_en, 0);
        cyc();
        cu_dwen = 0; dhit = 1;
        #1;
        chk("st_t1_dmemWEN", dmemWEN, 1);
        chk("st_t1_dmemREN", dmemREN, 0);
        chk("st_t1_imemREN", imemREN, 0);
        chk("st_t1_pc_en", pc_en, 1);
        cyc();
        ihit = 0; dhit = 0;
        chk("st_t2_dmemWEN", dmemWEN, 0);
        chk("st_instr", instr_count, 5);
        chk("st_stall", stall_count, 2);

        // dren & dwen together is a store
        ihit = 1; cu_dren = 1; cu_dwen = 1;
        #1;
        chk("rw_t0_pc_en", pc_en, 0);
        cyc();
        ihit = 0; cu_dren = 0; cu_dwen = 0; dhit = 1;
        #1;
        chk("rw_dmemWEN", dmemWEN, 1);
        chk("rw_dmemREN", dmemREN, 0);
        chk("rw_pc_en", pc_en, 1);
        cyc();
        dhit = 0;
        chk("rw_instr", instr_count, 6);
        chk("rw_stall", stall_count, 2);

        // Asynchronous reset while a load is outstanding
        ihit = 1; cu_dren = 1;
        cyc();
        ihit = 0; cu_dren = 0;
        chk("ar_pre_dmemREN", dmemREN, 1);
        #2;
        nRST = 1'b0;
        #1;
        chk("ar_dmemREN", dmemREN, 0);
        chk("ar_imemREN", imemREN, 0);
        chk("ar_instr", instr_count, 0);
        chk("ar_stall", stall_count, 0);
        cyc();
        nRST = 1'b1;
        #1;
        chk("ar_rel_imemREN", imemREN, 1);
        cyc();
        chk("ar_rel_stall", stall_count, 1);

        // HALT beats store; HALTED absorbs everything
        ihit = 1; cu_halt = 1; cu_dwen = 1;
        #1;
        chk("h_t0_pc_en", pc_en, 0);
        chk("h_t0_imemREN", imemREN, 1);
        cyc();
        cu_halt = 0; cu_dwen = 0; dhit = 1;
        chk("h_halt", halt, 1);
        chk("h_instr", instr_count, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("h_pc_en", pc_en, 0);
            chk("h_dmemWEN", dmemWEN, 0);
            chk("h_imemREN", imemREN, 0);
            cyc();
        end
        chk("h_halt_hold", halt, 1);
        chk("h_instr_frz", instr_count, 1);
        chk("h_stall_frz", stall_count, 1);

        // Saturation with the 4-bit instance
        idle_inputs();
        nRST = 1'b0;
        cyc();
        nRST = 1'b1;
        ihit4 = 1;
        repeat (14) cyc();
        chk("sat_instr14", instr_count4, 14);
        chk("sat_stall0", stall_count4, 0);
        repeat (6) cyc();
        chk("sat_instr15", instr_count4, 15);
        chk("sat_pc_en", pc_en4, 1);
        ihit4 = 0;
        repeat (20) cyc();
        chk("sat_stall15", stall_count4, 15);
        chk("sat_instr_hold", instr_count4, 15);
        chk("wide_stall40", stall_count, 40);
        chk("wide_instr0", instr_count, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
